// File: rtl/fetch_exec_sequencer_if.sv
// Control/status bundle between fetch_exec_sequencer and the datapath it drives.
// Optional macro FES_SINGLE_STEP_EN adds the Step input.
interface fetch_exec_sequencer_if #(
    parameter int unsigned INSTR_CNT_W = 8
);
    logic                   Start;
    logic [15:0]            IR_Q;
    logic                   IR_En;
    logic                   IR_LH;
    logic [1:0]             IR_FunSel;
    logic [3:0]             ARF_RegSel;
    logic [1:0]             ARF_FunSel;
    logic [1:0]             ARF_OutDSel;
    logic [3:0]             RF_RegSel;
    logic [1:0]             RF_FunSel;
    logic                   RF_ISel;
    logic                   Busy;
    logic                   Halted;
    logic                   Illegal;
    logic [INSTR_CNT_W-1:0] InstrCnt;
`ifdef FES_SINGLE_STEP_EN
    logic                   Step;

    modport master (
        input  Start, IR_Q, Step,
        output IR_En, IR_LH, IR_FunSel, ARF_RegSel, ARF_FunSel, ARF_OutDSel,
               RF_RegSel, RF_FunSel, RF_ISel, Busy, Halted, Illegal, InstrCnt
    );
    modport slave (
        output Start, IR_Q, Step,
        input  IR_En, IR_LH, IR_FunSel, ARF_RegSel, ARF_FunSel, ARF_OutDSel,
               RF_RegSel, RF_FunSel, RF_ISel, Busy, Halted, Illegal, InstrCnt
    );
`else
    modport master (
        input  Start, IR_Q,
        output IR_En, IR_LH, IR_FunSel, ARF_RegSel, ARF_FunSel, ARF_OutDSel,
               RF_RegSel, RF_FunSel, RF_ISel, Busy, Halted, Illegal, InstrCnt
    );
    modport slave (
        output Start, IR_Q,
        input  IR_En, IR_LH, IR_FunSel, ARF_RegSel, ARF_FunSel, ARF_OutDSel,
               RF_RegSel, RF_FunSel, RF_ISel, Busy, Halted, Illegal, InstrCnt
    );
`endif
endinterface

// File: rtl/fetch_exec_sequencer.sv
// Hardwired fetch-low / fetch-high / decode / execute sequencer for the ARF/IR/RegFile
// datapath. All control outputs are Moore-decoded from state (EX also decodes IR_Q).
// Optional macro FES_SINGLE_STEP_EN adds a PAUSE state released by a rising edge of Step.
module fetch_exec_sequencer #(
    parameter int unsigned INSTR_CNT_W   = 8,
    parameter int unsigned ILLEGAL_HALTS = 0
) (
    input logic                    CLK,
    input logic                    RST_N,
    fetch_exec_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StF0,
        StF1,
        StDec,
        StEx,
        StHalt
`ifdef FES_SINGLE_STEP_EN
        , StPause
`endif
    } state_e;

    localparam logic [1:0] FunDec = 2'b00;
    localparam logic [1:0] FunInc = 2'b01;
    localparam logic [1:0] FunLd  = 2'b10;
    localparam logic [1:0] FunClr = 2'b11;

    localparam logic [3:0] SelPc = 4'b0001;
    localparam logic [3:0] SelAr = 4'b0010;

    localparam logic [INSTR_CNT_W-1:0] CntOne = INSTR_CNT_W'(1);

    state_e                 r_state;
    state_e                 w_next_state;
    state_e                 w_ex_done_state;
    logic [INSTR_CNT_W-1:0] r_instr_cnt;

    logic [3:0] w_opcode;
    logic [3:0] w_rx_onehot;
    logic       w_unused_ir;

    logic       w_ir_en;
    logic       w_ir_lh;
    logic [1:0] w_ir_funsel;
    logic [3:0] w_arf_regsel;
    logic [1:0] w_arf_funsel;
    logic [1:0] w_arf_outdsel;
    logic [3:0] w_rf_regsel;
    logic [1:0] w_rf_funsel;
    logic       w_rf_isel;
    logic       w_busy;
    logic       w_halted;
    logic       w_illegal;

    assign w_opcode    = bus.IR_Q[15:12];
    assign w_rx_onehot = 4'b0001 << bus.IR_Q[9:8];
    // Immediate feeds the datapath directly; bits 11:10 are don't-care.
    assign w_unused_ir = ^{bus.IR_Q[11:10], bus.IR_Q[7:0]};

`ifdef FES_SINGLE_STEP_EN
    logic r_step_q;
    logic w_step_rise;

    assign w_step_rise     = bus.Step & ~r_step_q;
    assign w_ex_done_state = StPause;

    // Step edge-detect history.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= bus.Step;
        end
    end
`else
    assign w_ex_done_state = StF0;
`endif

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Retired-instruction counter; every EX cycle retires exactly one instruction.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_instr_cnt <= '0;
        end else if (r_state == StEx) begin
            r_instr_cnt <= r_instr_cnt + CntOne;
        end
    end

    // Next-state and Moore control decode.
    always_comb begin
        w_next_state  = r_state;
        w_ir_en       = 1'b0;
        w_ir_lh       = 1'b0;
        w_ir_funsel   = 2'b00;
        w_arf_regsel  = 4'b0000;
        w_arf_funsel  = 2'b00;
        w_arf_outdsel = 2'b00;
        w_rf_regsel   = 4'b0000;
        w_rf_funsel   = 2'b00;
        w_rf_isel     = 1'b0;
        w_busy        = 1'b0;
        w_halted      = 1'b0;
        w_illegal     = 1'b0;
        case (r_state)
            StIdle: begin
                if (bus.Start) begin
                    w_next_state = StInit;
                end
            end
            StInit: begin
                w_busy       = 1'b1;
                w_arf_regsel = SelPc;
                w_arf_funsel = FunClr;
                w_next_state = StF0;
            end
            StF0, StF1: begin
                w_busy        = 1'b1;
                w_arf_outdsel = 2'b00;
                w_ir_en       = 1'b1;
                w_ir_lh       = (r_state == StF1);
                w_ir_funsel   = FunLd;
                w_arf_regsel  = SelPc;
                w_arf_funsel  = FunInc;
                w_next_state  = (r_state == StF0) ? StF1 : StDec;
            end
            StDec: begin
                w_busy       = 1'b1;
                w_next_state = StEx;
            end
            StEx: begin
                w_busy       = 1'b1;
                w_next_state = w_ex_done_state;
                case (w_opcode)
                    4'b0000: ;
                    4'b0001: begin
                        w_rf_regsel = w_rx_onehot;
                        w_rf_funsel = FunLd;
                        w_rf_isel   = 1'b0;
                    end
                    4'b0010: begin
                        w_arf_outdsel = 2'b01;
                        w_rf_regsel   = w_rx_onehot;
                        w_rf_funsel   = FunLd;
                        w_rf_isel     = 1'b1;
                    end
                    4'b0011: begin
                        w_rf_regsel = w_rx_onehot;
                        w_rf_funsel = FunInc;
                    end
                    4'b0100: begin
                        w_rf_regsel = w_rx_onehot;
                        w_rf_funsel = FunDec;
                    end
                    4'b0101: begin
                        w_rf_regsel = w_rx_onehot;
                        w_rf_funsel = FunClr;
                    end
                    4'b0110: begin
                        w_arf_regsel = SelPc;
                        w_arf_funsel = FunLd;
                    end
                    4'b0111: begin
                        w_arf_regsel = SelAr;
                        w_arf_funsel = FunLd;
                    end
                    4'b1111: begin
                        w_next_state = StHalt;
                    end
                    default: begin
                        w_illegal = 1'b1;
                        if (ILLEGAL_HALTS != 0) begin
                            w_next_state = StHalt;
                        end
                    end
                endcase
            end
            StHalt: begin
                w_halted = 1'b1;
            end
`ifdef FES_SINGLE_STEP_EN
            StPause: begin
                if (w_step_rise) begin
                    w_next_state = StF0;
                end
            end
`endif
            default: begin
                w_next_state = StIdle;
            end
        endcase
    end

    assign bus.IR_En       = w_ir_en;
    assign bus.IR_LH       = w_ir_lh;
    assign bus.IR_FunSel   = w_ir_funsel;
    assign bus.ARF_RegSel  = w_arf_regsel;
    assign bus.ARF_FunSel  = w_arf_funsel;
    assign bus.ARF_OutDSel = w_arf_outdsel;
    assign bus.RF_RegSel   = w_rf_regsel;
    assign bus.RF_FunSel   = w_rf_funsel;
    assign bus.RF_ISel     = w_rf_isel;
    assign bus.Busy        = w_busy;
    assign bus.Halted      = w_halted;
    assign bus.Illegal     = w_illegal;
    assign bus.InstrCnt    = r_instr_cnt;

endmodule
